// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants and loader state encoding.
// Imported by the instruction encoder and the imem loader.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH
   } state_e;

endpackage

// File: rtl/rv32_instr_encode.sv
// Combinational RV32I field packer; inverse of the core immediate generator.
// Flags immediates that do not fit their format or are misaligned.
module rv32_instr_encode
   import riscv_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        range_err
);

   logic fit12;
   logic fit13;
   logic fit21;
   logic is_shift;

   assign fit12    = (imm[31:11] == {21{imm[11]}});
   assign fit13    = (imm[31:12] == {20{imm[12]}});
   assign fit21    = (imm[31:20] == {12{imm[20]}});
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      instr     = NOP;
      range_err = 1'b0;
      case (opcode)
         OP_R: begin
            instr = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            // Shift-immediates carry funct7 above a 5-bit shamt
            if (opcode == OP_IMM && is_shift) begin
               instr     = {funct7, imm[4:0], rs1, funct3, rd, opcode};
               range_err = (imm[31:5] != 27'd0);
            end else begin
               instr     = {imm[11:0], rs1, funct3, rd, opcode};
               range_err = !fit12;
            end
         end
         OP_STORE: begin
            instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            range_err = !fit12;
         end
         OP_BRANCH: begin
            instr     = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
            range_err = !fit13 || imm[0];
         end
         OP_LUI, OP_AUIPC: begin
            instr     = {imm[31:12], rd, opcode};
            range_err = (imm[11:0] != 12'd0);
         end
         OP_JAL: begin
            instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            range_err = !fit21 || imm[0];
         end
         default: begin
            instr     = NOP;
            range_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams RV32I field bundles, encodes them and writes them to imem
// at consecutive word addresses starting from a programmed base.
module instr_encode_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  err_idx
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  err_idx_q, err_idx_d;
   logic              rdy_q, rdy_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [31:0] enc;
   logic        enc_err;
   logic        accept;

   rv32_instr_encode u_enc (
      .opcode    (in_opcode),
      .rd        (in_rd),
      .rs1       (in_rs1),
      .rs2       (in_rs2),
      .funct3    (in_funct3),
      .funct7    (in_funct7),
      .imm       (in_imm),
      .instr     (enc),
      .range_err (enc_err)
   );

   assign accept = in_valid && rdy_q;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d    = base_addr;
               cnt_d     = count;
               idx_d     = '0;
               err_d     = 1'b0;
               err_idx_d = '0;
               state_d   = (count == '0) ? S_FLUSH : S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = base_q + idx_q[ADDR_W-1:0];
               wdata_d = enc;
               idx_d   = idx_q + CNT_W'(1);
               if (enc_err && !err_q) begin
                  err_d     = 1'b1;
                  err_idx_d = idx_q;
               end
               if (idx_q == cnt_q - CNT_W'(1)) state_d = S_FLUSH;
            end
         end
         S_FLUSH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Status flags are registered alongside the next state
      rdy_d  = (state_d == S_LOAD);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign in_ready   = rdy_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected imem writes and
// session-end status are queued by stimulus and checked by a monitor.
module tb_instr_encode_loader;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 11;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  count;
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [31:0]       in_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [CNT_W-1:0]  err_idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct {
      logic             we;
      logic             err;
      logic [CNT_W-1:0] idx;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];

   always #5 clk = ~clk;

   instr_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_funct3  (in_funct3),
      .in_funct7  (in_funct7),
      .in_imm     (in_imm),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_idx    (err_idx)
   );

   // Monitor: compare every write and every done pulse against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_we) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
               wr_t w;
               w = wq.pop_front();
               if (imem_addr !== w.addr || imem_wdata !== w.data) begin
                  errors++;
                  $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                           imem_addr, imem_wdata, w.addr, w.data);
               end
            end
         end
         if (done) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done");
            end else begin
               dn_t d;
               d = dq.pop_front();
               if (imem_we !== d.we || err !== d.err || err_idx !== d.idx
                   || wq.size() != 0) begin
                  errors++;
                  $display("FAIL done got we=%b err=%b idx=%0d pend=%0d want we=%b err=%b idx=%0d pend=0",
                           imem_we, err, err_idx, wq.size(), d.we, d.err, d.idx);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
      start     = 1'b1;
      base_addr = b;
      count     = c;
      tick();
      start     = 1'b0;
   endtask

   task automatic expect_done(input logic we, input logic e, input logic [CNT_W-1:0] i);
      dn_t d;
      d.we  = we;
      d.err = e;
      d.idx = i;
      dq.push_back(d);
   endtask

   task automatic beat(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm,
                       input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
      int  n = 0;
      wr_t w;
      w.addr = ea;
      w.data = ed;
      wq.push_back(w);
      in_valid  = 1'b1;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = r1;
      in_rs2    = r2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout in_ready=0 want 1");
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL idle_timeout busy=1 want 0");
      end
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_idx} !== '0) begin
         errors++;
         $display("FAIL %s rdy=%b we=%b addr=%h wd=%h busy=%b done=%b err=%b idx=%0d want all 0",
                  tag, in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_idx);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
      in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
      in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) tick();
      check_reset_outputs("reset_state");
      rst = 1'b0;
      tick();

      // ADDI / SW / BEQ back-to-back
      expect_done(1'b1, 1'b0, 11'd0);
      do_start(10'h010, 11'd3);
      beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,  10'h010, 32'h0050_0093);
      beat(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,  10'h011, 32'h0020_A423);
      beat(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 10'h012, 32'hFE20_8EE3);
      wait_idle();

      // JAL / LUI / SLLI
      expect_done(1'b1, 1'b0, 11'd0);
      do_start(10'h020, 11'd3);
      beat(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      10'h020, 32'h0010_00EF);
      beat(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 10'h021, 32'h1234_52B7);
      beat(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3,         10'h022, 32'h0030_9093);
      wait_idle();

      // Range error at index 1, alignment error at index 2
      expect_done(1'b1, 1'b1, 11'd1);
      do_start(10'h030, 11'd3);
      beat(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,    10'h030, 32'h0010_0113);
      beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 10'h031, 32'h8000_0093);
      beat(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,    10'h032, 32'h0000_0163);
      wait_idle();

      // Empty session
      expect_done(1'b0, 1'b0, 11'd0);
      do_start(10'h040, 11'd0);
      wait_idle();

      // Address wrap
      expect_done(1'b1, 1'b0, 11'd0);
      do_start(10'h3FF, 11'd2);
      beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 10'h3FF, 32'h0050_0093);
      beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 10'h000, 32'h0050_0093);
      wait_idle();

      // Gaps in in_valid and an ignored start while busy
      expect_done(1'b1, 1'b0, 11'd0);
      do_start(10'h050, 11'd3);
      beat(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 10'h050, 32'h0020_81B3);
      tick();
      do_start(10'h100, 11'd5);
      beat(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 10'h051, 32'h4020_81B3);
      tick();
      beat(7'h03, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, -32'sd1, 10'h052, 32'hFFF1_2203);
      wait_idle();

      // Unknown opcode writes a NOP
      expect_done(1'b1, 1'b1, 11'd0);
      do_start(10'h060, 11'd1);
      beat(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 10'h060, 32'h0000_0013);
      wait_idle();

      // Reset in the middle of a session discards the beat
      do_start(10'h070, 11'd3);
      in_valid  = 1'b1;
      in_opcode = 7'h13;
      in_imm    = 32'd7;
      rst       = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      tick();
      check_reset_outputs("after_reset");

      expect_done(1'b1, 1'b0, 11'd0);
      do_start(10'h080, 11'd1);
      beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 10'h080, 32'h0050_0093);
      wait_idle();
      tick();

      checks++;
      if (wq.size() != 0 || dq.size() != 0) begin
         errors++;
         $display("FAIL leftover writes=%0d dones=%0d want 0 0", wq.size(), dq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
